// File: rtl/alu_issue_stage.sv
// Decode/issue register in front of the RV32I execute ALU: decodes ALU-class ops,
// resolves operands and presents A/B/op_dec via valid/ready. EX bypass under `ALU_ISSUE_FWD_EN.
module alu_issue_stage #(
  parameter int XLEN = 32,
  parameter int OPW  = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic            flush,
  input  logic            ex_we,
  input  logic [4:0]      ex_rd,
  input  logic [XLEN-1:0] ex_result,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] A,
  output logic [XLEN-1:0] B,
  output logic [OPW-1:0]  op_dec,
  output logic [4:0]      rd,
  output logic            rd_we,
  output logic            illegal
);

  localparam logic [OPW-1:0] OP_ADD = 4'b0000;
  localparam logic [OPW-1:0] OP_SUB = 4'b0001;
  localparam logic [OPW-1:0] OP_SLT = 4'b0010;
  localparam logic [OPW-1:0] OP_AND = 4'b0011;
  localparam logic [OPW-1:0] OP_OR  = 4'b0100;
  localparam logic [OPW-1:0] OP_XOR = 4'b0101;
  localparam logic [OPW-1:0] OP_SLL = 4'b0110;
  localparam logic [OPW-1:0] OP_SRL = 4'b0111;
  localparam logic [OPW-1:0] OP_SRA = 4'b1000;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [6:0] F7_ZERO = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef struct packed {
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [OPW-1:0]  op;
    logic            we;
    logic            ill;
  } dec_t;

  logic [6:0] opc;
  logic [2:0] f3;
  logic [6:0] f7;
  logic [4:0] rs1_f, rs2_f, rd_f;
  logic [XLEN-1:0] imm_i, imm_u, shamt_i;
  logic [XLEN-1:0] src1, src2, src2_sh;

  assign opc     = instr[6:0];
  assign rd_f    = instr[11:7];
  assign f3      = instr[14:12];
  assign rs1_f   = instr[19:15];
  assign rs2_f   = instr[24:20];
  assign f7      = instr[31:25];
  assign imm_i   = {{(XLEN-12){instr[31]}}, instr[31:20]};
  assign imm_u   = {instr[31:12], 12'b0};
  assign shamt_i = {{(XLEN-5){1'b0}}, instr[24:20]};

`ifdef ALU_ISSUE_FWD_EN
  assign src1 = (ex_we && ex_rd != 5'd0 && ex_rd == rs1_f) ? ex_result : rs1_data;
  assign src2 = (ex_we && ex_rd != 5'd0 && ex_rd == rs2_f) ? ex_result : rs2_data;
`else
  logic unused_fwd;
  assign unused_fwd = ^{ex_we, ex_rd, ex_result, rs1_f, rs2_f};
  assign src1 = rs1_data;
  assign src2 = rs2_data;
`endif

  // The ALU shifts by the whole B, so register shift amounts are trimmed after bypass.
  assign src2_sh = {{(XLEN-5){1'b0}}, src2[4:0]};

  dec_t dec;

  always_comb begin
    dec     = '0;
    dec.ill = 1'b1;
    unique case (opc)
      OPC_OP: begin
        dec.a   = src1;
        dec.b   = src2;
        dec.we  = 1'b1;
        dec.ill = 1'b0;
        unique case (f3)
          3'b000: if (f7 == F7_ZERO) dec.op = OP_ADD;
                  else if (f7 == F7_ALT) dec.op = OP_SUB;
                  else dec.ill = 1'b1;
          3'b001: begin
            dec.b = src2_sh;
            if (f7 == F7_ZERO) dec.op = OP_SLL; else dec.ill = 1'b1;
          end
          3'b010: if (f7 == F7_ZERO) dec.op = OP_SLT; else dec.ill = 1'b1;
          3'b100: if (f7 == F7_ZERO) dec.op = OP_XOR; else dec.ill = 1'b1;
          3'b101: begin
            dec.b = src2_sh;
            if (f7 == F7_ZERO) dec.op = OP_SRL;
            else if (f7 == F7_ALT) dec.op = OP_SRA;
            else dec.ill = 1'b1;
          end
          3'b110: if (f7 == F7_ZERO) dec.op = OP_OR;  else dec.ill = 1'b1;
          3'b111: if (f7 == F7_ZERO) dec.op = OP_AND; else dec.ill = 1'b1;
          default: dec.ill = 1'b1;  // SLTU: no unsigned compare in this ALU
        endcase
      end
      OPC_OPIMM: begin
        dec.a   = src1;
        dec.b   = imm_i;
        dec.we  = 1'b1;
        dec.ill = 1'b0;
        unique case (f3)
          3'b000: dec.op = OP_ADD;
          3'b010: dec.op = OP_SLT;
          3'b100: dec.op = OP_XOR;
          3'b110: dec.op = OP_OR;
          3'b111: dec.op = OP_AND;
          3'b001: begin
            dec.b = shamt_i;
            if (f7 == F7_ZERO) dec.op = OP_SLL; else dec.ill = 1'b1;
          end
          3'b101: begin
            dec.b = shamt_i;
            if (f7 == F7_ZERO) dec.op = OP_SRL;
            else if (f7 == F7_ALT) dec.op = OP_SRA;
            else dec.ill = 1'b1;
          end
          default: dec.ill = 1'b1;
        endcase
      end
      OPC_LUI: begin
        dec.a   = '0;
        dec.b   = imm_u;
        dec.op  = OP_ADD;
        dec.we  = 1'b1;
        dec.ill = 1'b0;
      end
      OPC_AUIPC: begin
        dec.a   = pc;
        dec.b   = imm_u;
        dec.op  = OP_ADD;
        dec.we  = 1'b1;
        dec.ill = 1'b0;
      end
      OPC_BRANCH: begin
        // Compare via SUB; flags are consumed downstream. f3 010/011 are not branches.
        if (f3 != 3'b010 && f3 != 3'b011) begin
          dec.a   = src1;
          dec.b   = src2;
          dec.op  = OP_SUB;
          dec.ill = 1'b0;
        end
      end
      default: dec.ill = 1'b1;
    endcase
    if (dec.ill) begin
      dec.a  = '0;
      dec.b  = '0;
      dec.op = OP_ADD;
      dec.we = 1'b0;
    end
    if (rd_f == 5'd0) dec.we = 1'b0;
  end

  logic            out_valid_q, out_valid_d;
  logic [XLEN-1:0] a_q, a_d, b_q, b_d;
  logic [OPW-1:0]  op_q, op_d;
  logic [4:0]      rd_q, rd_d;
  logic            rd_we_q, rd_we_d;
  logic            ill_q, ill_d;
  logic            cap;

  assign in_ready = !out_valid_q || out_ready;
  assign cap      = in_valid && in_ready && !flush;

  always_comb begin
    out_valid_d = out_valid_q;
    a_d         = a_q;
    b_d         = b_q;
    op_d        = op_q;
    rd_d        = rd_q;
    rd_we_d     = rd_we_q;
    ill_d       = ill_q;
    if (flush) begin
      out_valid_d = 1'b0;
      rd_we_d     = 1'b0;
    end else if (cap) begin
      out_valid_d = 1'b1;
      a_d         = dec.a;
      b_d         = dec.b;
      op_d        = dec.op;
      rd_d        = rd_f;
      rd_we_d     = dec.we;
      ill_d       = dec.ill;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= OP_ADD;
      rd_q        <= '0;
      rd_we_q     <= 1'b0;
      ill_q       <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      a_q         <= a_d;
      b_q         <= b_d;
      op_q        <= op_d;
      rd_q        <= rd_d;
      rd_we_q     <= rd_we_d;
      ill_q       <= ill_d;
    end
  end

  assign out_valid = out_valid_q;
  assign A         = a_q;
  assign B         = b_q;
  assign op_dec    = op_q;
  assign rd        = rd_q;
  assign rd_we     = rd_we_q;
  assign illegal   = ill_q;

endmodule
